// File: rtl/hazard_sched_ctrl.sv
// hazard_sched_ctrl
//   Pipeline hazard scheduler for the 5-stage core. Each cycle it decides
//   whether the front end stalls and which pipeline registers are flushed.
//   It handles the hazards that forwarding cannot resolve:
//     - load-use (a load in EX feeds an instruction in DECODE),
//     - a taken branch/jump resolved in EX,
//     - multicycle EX ops (MUL/DIV), for which it also sequences the
//       multicycle unit (start pulse, fixed busy window, done pulse).
//
// Ports
//   clk, rst           core clock; asynchronous active-high reset
//   rs1_D, rs2_D       source register addresses of the DECODE instruction
//   rd_E               destination register address of the EX instruction
//   MemRead_E          EX instruction is a load
//   RegW_E             EX instruction writes the register file
//   mc_op_E            EX instruction is a multicycle op
//   branch_taken_E     branch/jump resolved taken in EX
//   stall_F/D/E        hold PC, IF/ID, ID/EX
//   flush_D/E/M        clear IF/ID, ID/EX, EX/MEM to NOP
//   mc_start           one-cycle launch pulse to the multicycle unit
//   mc_done            result-valid cycle; EX/MEM captures the unit result
//   mc_busy            high while the multicycle unit is working
//
// All outputs are combinational from state, counter and inputs, and are
// forced to 0 while rst is high.
module hazard_sched_ctrl #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,   // multicycle latency, >= 2
    parameter int CNT_W  = 2    // 2**CNT_W >= MC_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rd_E,
    input  logic              MemRead_E,
    input  logic              RegW_E,
    input  logic              mc_op_E,
    input  logic              branch_taken_E,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic              mc_start,
    output logic              mc_done,
    output logic              mc_busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lu;

    // Ungated versions of the outputs; rst masks them below.
    logic stall_f_c, stall_d_c, stall_e_c;
    logic flush_d_c, flush_e_c, flush_m_c;
    logic mc_start_c, mc_done_c, mc_busy_c;

    // Register x0 is hard-wired zero, so it never creates a dependency.
    assign lu = MemRead_E & RegW_E & (rd_E != '0) &
                ((rd_E == rs1_D) | (rd_E == rs2_D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        stall_e_c  = 1'b0;
        flush_d_c  = 1'b0;
        flush_e_c  = 1'b0;
        flush_m_c  = 1'b0;
        mc_start_c = 1'b0;
        mc_done_c  = 1'b0;
        mc_busy_c  = 1'b0;

        case (state_q)
            RUN: begin
                if (mc_op_E) begin
                    // Launch: freeze the front end and keep the op out of MEM
                    // until its result is ready.
                    mc_start_c = 1'b1;
                    stall_f_c  = 1'b1;
                    stall_d_c  = 1'b1;
                    stall_e_c  = 1'b1;
                    flush_m_c  = 1'b1;
                    cnt_d      = CNT_W'(MC_LAT - 1);
                    state_d    = MC_BUSY;
                end else if (branch_taken_E) begin
                    // Wrong-path instructions in IF/ID and ID/EX are discarded;
                    // any load-use against them is moot.
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (lu) begin
                    // One bubble: after it the load sits in MEM and forwarding
                    // takes over.
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end

            MC_BUSY: begin
                mc_busy_c = 1'b1;
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
                flush_m_c = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MC_DONE;
                end
            end

            MC_DONE: begin
                // The op leaves EX this cycle. mc_op_E still reflects it, so it
                // is ignored here to avoid relaunching the same instruction.
                mc_done_c = 1'b1;
                cnt_d     = '0;
                state_d   = RUN;
                if (branch_taken_E) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (lu) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end

            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_F  = stall_f_c  & ~rst;
    assign stall_D  = stall_d_c  & ~rst;
    assign stall_E  = stall_e_c  & ~rst;
    assign flush_D  = flush_d_c  & ~rst;
    assign flush_E  = flush_e_c  & ~rst;
    assign flush_M  = flush_m_c  & ~rst;
    assign mc_start = mc_start_c & ~rst;
    assign mc_done  = mc_done_c  & ~rst;
    assign mc_busy  = mc_busy_c  & ~rst;

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage core.
- Decides, each cycle, when stages stall and when bubbles are inserted. Covers three hazards: load-use, taken branch in EX, and multicycle EX ops (MUL/DIV).
- Sequences the multicycle unit: start pulse, fixed-latency busy window, done pulse.
- Sits beside the forwarding-select decoder. Forwarding resolves ALU-to-ALU dependencies; this block handles everything forwarding cannot.

Parameters:
- REG_AW, 5, register address width.
- MC_LAT, 4, multicycle unit latency in cycles; must be ≥2.
- CNT_W, 2, busy counter width; must satisfy 2^CNT_W ≥ MC_LAT.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- rs1_D  in  REG_AW  source 1 address of instruction in DECODE.
- rs2_D  in  REG_AW  source 2 address of instruction in DECODE.
- rd_E  in  REG_AW  destination address of instruction in EX.
- MemRead_E  in  1  instruction in EX is a load.
- RegW_E  in  1  instruction in EX writes the register file.
- mc_op_E  in  1  instruction in EX is a multicycle op.
- branch_taken_E  in  1  branch/jump resolved taken in EX.
- stall_F  out  1  hold PC.
- stall_D  out  1  hold IF/ID register.
- stall_E  out  1  hold ID/EX register.
- flush_D  out  1  clear IF/ID to NOP.
- flush_E  out  1  clear ID/EX to NOP.
- flush_M  out  1  clear EX/MEM to NOP.
- mc_start  out  1  one-cycle launch pulse to multicycle unit.
- mc_done  out  1  result-valid cycle; EX/MEM captures the unit result.
- mc_busy  out  1  high while FSM is in MC_BUSY.

Behaviour:
- FSM states: RUN, MC_BUSY, MC_DONE. Counter cnt is CNT_W bits. Both are updated on the clk rising edge.
- Reset:
  - state=RUN, cnt=0 asynchronously.
  - Every output is forced to 0 combinationally while rst=1.
  - Reset mid-MC_BUSY aborts the op: no mc_done is produced, and the next cycle after release is RUN.
- Load-use (lu):
  - lu = MemRead_E & RegW_E & (rd_E≠0) & ((rd_E==rs1_D) | (rd_E==rs2_D)).
  - Register x0 never causes a hazard.
- RUN, priority highest first:
  1. mc_op_E=1:
     - mc_start=1; stall_F=stall_D=stall_E=1; flush_M=1.
     - cnt←MC_LAT-1; next state MC_BUSY.
     - branch_taken_E and lu are ignored this cycle.
  2. branch_taken_E=1:
     - flush_D=1, flush_E=1; no stalls; lu is ignored.
  3. lu=1:
     - stall_F=stall_D=1, flush_E=1 (one bubble).
     - Then re-evaluated next cycle; after the bubble, the load is in MEM, so lu clears.
  4. Otherwise all outputs are 0.
- MC_BUSY:
  - mc_busy=1; stall_F=stall_D=stall_E=1; flush_M=1. All other inputs are ignored.
  - cnt←cnt-1. When cnt==1, next state is MC_DONE.
- MC_DONE:
  - mc_done=1; no stalls; mc_op_E is ignored, so the op is not relaunched.
  - The multicycle instruction advances to MEM at the end of this cycle.
  - lu and branch_taken_E are evaluated as in RUN (steps 2–4).
  - Next state RUN.
- Timing: a multicycle op stalls the front end for exactly MC_LAT cycles (launch cycle plus MC_LAT-1 busy cycles). mc_done follows in the next cycle. mc_start and mc_done are each high for exactly one cycle per op.
- Back-to-back multicycle ops: the second op reaches EX in the cycle after MC_DONE, where the FSM is in RUN, and launches normally.
- Stall/flush conflict on the same register: flush wins. stall_D and flush_D are never both 1, and stall_E and flush_E are never both 1.
- All outputs except state and cnt are combinational from state, cnt and inputs. There are no registered outputs.

Test Plan:
- Load-use: MemRead_E=1, RegW_E=1, rd_E=5, rs1_D=5, RUN → stall_F=stall_D=flush_E=1 for 1 cycle. Repeat with rd_E=0 → all outputs 0.
- Branch plus load-use: lu conditions true and branch_taken_E=1 → flush_D=flush_E=1, stall_F=0, stall_D=0.
- Multicycle op, MC_LAT=4: mc_op_E=1 held →
  - mc_start=1 in cycle 0;
  - mc_busy=1 in cycles 1–3;
  - stalls and flush_M high in cycles 0–3;
  - mc_done=1 in cycle 4, stalls 0;
  - cycle 5 in RUN, with no relaunch in cycle 4.
- Multicycle op with simultaneous branch_taken_E=1 and lu=1 → MC path wins; flush_D=0, flush_E=0.
- Back-to-back multicycle ops → two mc_start pulses 5 cycles apart. Load-use during MC_DONE → stall_F=1 in that cycle.
- Reset mid-op: assert rst in cycle 2 of MC_BUSY → all outputs 0 immediately, no mc_done; after release, state RUN and mc_op_E=0 gives no outputs.
